// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC request-channel types and default widths
package noc_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/noc_resp_regfile.sv
// rtl/noc_resp_regfile.sv - 2^AW x W register array, synchronous write, registered read, async clear
module noc_resp_regfile #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wrstn,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // rdata is only reloaded on re, so it holds its last value between reads
  always_ff @(posedge clk or negedge wrstn) begin
    if (!wrstn) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/noc_slave_responder.sv
// rtl/noc_slave_responder.sv - NoC slave endpoint: request FSM, wait counter, local register array
// Optional parity storage and checking enabled by NOC_RESP_PARITY_EN.
module noc_slave_responder
  import noc_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          wrstn,
  input  logic          req_write,
  input  logic          req_read,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy
`ifdef NOC_RESP_PARITY_EN
  ,
  input  logic          wpar,
  output logic          rpar,
  output logic          par_err
`endif
);

`ifdef NOC_RESP_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  state_t        state_q, state_d;
  op_t           op_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic [3:0]    cnt_q;
  logic          req_any;
  logic          rd_en, wr_en;
  logic [MW-1:0] rf_wdata, rf_rdata;

  assign req_any = req_write | req_read;

  always_ff @(posedge clk or negedge wrstn) begin
    if (!wrstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The read is launched on the edge entering ACK so rdata is registered for the whole ACK cycle
  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    busy    = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req_any) state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          rd_en   = (op_l == OP_RD);
        end
      end
      ACK: begin
        ack     = 1'b1;
        wr_en   = (op_l == OP_WR);
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge wrstn) begin
    if (!wrstn) begin
      cnt_q   <= 4'd0;
      addr_l  <= '0;
      wdata_l <= '0;
      op_l    <= OP_WR;
    end else if (state_q == IDLE && req_any) begin
      cnt_q   <= 4'(WAIT);
      addr_l  <= addr;
      wdata_l <= wdata;
      op_l    <= req_write ? OP_WR : OP_RD;
    end else if (state_q == ACCESS && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

`ifdef NOC_RESP_PARITY_EN
  logic wpar_l;

  always_ff @(posedge clk or negedge wrstn) begin
    if (!wrstn) begin
      wpar_l  <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (state_q == IDLE && req_any) wpar_l <= wpar;
      if (wr_en && (wpar_l != ^wdata_l)) par_err <= 1'b1;
    end
  end

  assign rf_wdata = {wpar_l, wdata_l};
  assign rpar     = rf_rdata[DW];
`else
  assign rf_wdata = wdata_l;
`endif

  assign rdata = rf_rdata[DW-1:0];

  noc_resp_regfile #(
    .W  (MW),
    .AW (AW)
  ) u_regfile (
    .clk   (clk),
    .wrstn (wrstn),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (addr_l),
    .wdata (rf_wdata),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_noc_slave_responder.sv
// tb/tb_noc_slave_responder.sv - randomized check of two responders (WAIT=0, WAIT=3) against a memory model
module tb_noc_slave_responder;

  logic       clk = 1'b0;
  logic       wrstn = 1'b0;
  logic       req_write = 1'b0;
  logic       req_read = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ack0, ack3, busy0, busy3;
  logic [7:0] rdata0, rdata3;
`ifdef NOC_RESP_PARITY_EN
  logic       wpar = 1'b0;
  logic       rpar0, rpar3, perr0, perr3;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem_m [16];
  logic       par_m [16];
  logic [7:0] last_rd;
  logic       perr_m;

  always #5 clk = ~clk;

  noc_slave_responder #(.DW(8), .AW(4), .WAIT(0)) dut0 (
    .clk(clk), .wrstn(wrstn), .req_write(req_write), .req_read(req_read),
    .addr(addr), .wdata(wdata), .ack(ack0), .rdata(rdata0), .busy(busy0)
`ifdef NOC_RESP_PARITY_EN
    , .wpar(wpar), .rpar(rpar0), .par_err(perr0)
`endif
  );

  noc_slave_responder #(.DW(8), .AW(4), .WAIT(3)) dut3 (
    .clk(clk), .wrstn(wrstn), .req_write(req_write), .req_read(req_read),
    .addr(addr), .wdata(wdata), .ack(ack3), .rdata(rdata3), .busy(busy3)
`ifdef NOC_RESP_PARITY_EN
    , .wpar(wpar), .rpar(rpar3), .par_err(perr3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = '0;
      par_m[i] = 1'b0;
    end
    last_rd = '0;
    perr_m  = 1'b0;
  endtask

  // One request from the requester's side: hold until both acks, plus 'hold' extra cycles
  task automatic txn(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d,
                     input bit wp, input int hold);
    int lat0, lat3, nack0, nack3, nbusy0, nbusy3, cyc, drop, exp_b0, exp_b3;
    logic [7:0] rd0, rd3;
    logic rp0, rp3;
    lat0 = -1; lat3 = -1; nack0 = 0; nack3 = 0; nbusy0 = 0; nbusy3 = 0;
    drop = -1; cyc = 0; rd0 = '0; rd3 = '0; rp0 = 1'b0; rp3 = 1'b0;
    req_write = wr; req_read = rd; addr = a; wdata = d;
`ifdef NOC_RESP_PARITY_EN
    wpar = wp;
`endif
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        addr  = 4'($urandom);
        wdata = 8'($urandom);
`ifdef NOC_RESP_PARITY_EN
        wpar  = 1'($urandom);
`endif
      end
      if (busy0) nbusy0++;
      if (busy3) nbusy3++;
      if (ack0) begin
        nack0++;
        if (lat0 < 0) begin
          lat0 = cyc; rd0 = rdata0;
`ifdef NOC_RESP_PARITY_EN
          rp0 = rpar0;
`endif
        end
      end
      if (ack3) begin
        nack3++;
        if (lat3 < 0) begin
          lat3 = cyc; rd3 = rdata3;
`ifdef NOC_RESP_PARITY_EN
          rp3 = rpar3;
`endif
        end
      end
      if (drop < 0 && lat0 > 0 && lat3 > 0 && cyc >= ((lat0 > lat3) ? lat0 : lat3) + hold) begin
        drop = cyc;
        req_write = 1'b0;
        req_read  = 1'b0;
      end
      if (drop > 0 && !busy0 && !busy3) break;
    end
    req_write = 1'b0;
    req_read  = 1'b0;
    check("lat_w0", lat0, 2);
    check("lat_w3", lat3, 5);
    check("nack_w0", nack0, 1);
    check("nack_w3", nack3, 1);
    exp_b0 = (drop > 3) ? drop : 3;
    exp_b3 = (drop > 6) ? drop : 6;
    check("busy_w0", nbusy0, exp_b0);
    check("busy_w3", nbusy3, exp_b3);
    if (wr) begin
      mem_m[a] = d;
      par_m[a] = wp;
      if (wp != ^d) perr_m = 1'b1;
    end else begin
      check("rdata_w0", rd0, mem_m[a]);
      check("rdata_w3", rd3, mem_m[a]);
      last_rd = mem_m[a];
`ifdef NOC_RESP_PARITY_EN
      check("rpar_w0", rp0, par_m[a]);
      check("rpar_w3", rp3, par_m[a]);
`endif
    end
    check("rdata_hold_w0", rdata0, last_rd);
    check("rdata_hold_w3", rdata3, last_rd);
`ifdef NOC_RESP_PARITY_EN
    check("perr_w0", perr0, perr_m);
    check("perr_w3", perr3, perr_m);
`endif
    rp0 = rp0 | rp3;
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] a;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ack", {ack0, ack3}, 2'b00);
    check("rst_busy", {busy0, busy3}, 2'b00);
    check("rst_rdata", {rdata0, rdata3}, 16'h0);
    wrstn = 1'b1;
    @(negedge clk);

    txn(1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 0);
    txn(1'b1, 1'b0, 4'h3, 8'hA5, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 0);
    txn(1'b1, 1'b1, 4'h7, 8'h3C, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h7, 8'h00, 1'b0, 0);
    txn(1'b1, 1'b0, 4'h9, 8'h5A, 1'b0, 10);
    txn(1'b0, 1'b1, 4'h9, 8'h00, 1'b0, 10);
    txn(1'b1, 1'b0, 4'h0, 8'hFF, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      a = 4'($urandom);
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1)
        txn(1'b1, 1'($urandom), a, d, ^d, $urandom_range(3, 0));
      else
        txn(1'b0, 1'b1, a, d, 1'b0, $urandom_range(3, 0));
    end

    txn(1'b1, 1'b0, 4'h2, 8'h11, 1'b0, 0);
    req_write = 1'b1; addr = 4'h2; wdata = 8'h55;
    @(negedge clk);
    wrstn = 1'b0;
    #1;
    check("midrst_ack", {ack0, ack3}, 2'b00);
    check("midrst_busy", {busy0, busy3}, 2'b00);
    check("midrst_rdata", {rdata0, rdata3}, 16'h0);
    req_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_noack", {ack0, ack3}, 2'b00);
    end
    wrstn = 1'b1;
    model_clear();
    @(negedge clk);
    txn(1'b0, 1'b1, 4'h2, 8'h00, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 0);

`ifdef NOC_RESP_PARITY_EN
    txn(1'b1, 1'b0, 4'h5, 8'h01, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 0);
    txn(1'b1, 1'b0, 4'h6, 8'h03, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h6, 8'h00, 1'b0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/noc_slave_responder.md
# noc_slave_responder

Slave-side endpoint of the NoC master/slave request channel. It receives write and read requests issued by the arbiter (`req_write`/`req_read`, address, data) and services them against a local register array. It answers each request with a single-cycle `ack` and, for reads, returns data alongside `ack`. It sits at the slave tile, terminating the handshake that the arbiter initiates.

## Interface
- `DW`, 8, data width
- `AW`, 4, address width; local array depth is 2^AW
- `WAIT`, 0, wait-state cycles inserted before `ack` (0–15)

- `clk`  in  1  clock
- `wrstn`  in  1  reset, asynchronous, active-low
- `req_write`  in  1  write request; level held by requester until `ack`
- `req_read`  in  1  read request; level held by requester until `ack`
- `addr`  in  AW  target word address
- `wdata`  in  DW  write data, valid while `req_write` high
- `ack`  out  1  one-cycle completion pulse
- `rdata`  out  DW  read data, valid only in the `ack` cycle of a read
- `busy`  out  1  high in every state except IDLE
- `wpar`, `rpar`, `par_err`: see Configuration

## Operation
- FSM states: IDLE, ACCESS, ACK, RELEASE.
- **IDLE:** on an edge with either request high:
  - latch `addr`, `wdata` and the op (write wins if both requests are high);
  - load the wait counter with `WAIT`;
  - move to ACCESS.
- **ACCESS:** counter decrements each edge. On the edge where the counter equals 0, move to ACK.
- **ACK:** `ack`=1 for exactly one cycle.
  - Write: `mem[addr_l] <= wdata_l` at the edge that leaves ACK.
  - Read: `rdata = mem[addr_l]`, driven registered and valid throughout the ACK cycle.
- **RELEASE:** stay until both requests are low, then return to IDLE. A held request is never serviced twice.
- Latched address and data are used throughout. Input changes after the IDLE sample are ignored.
- `rdata` holds its last value outside ACK.
- Reset (async, mid-operation included):
  - state goes to IDLE; `ack`, `busy`, `rdata`, the counter and `par_err` are cleared;
  - the memory array is cleared to 0;
  - any in-flight write is dropped.
- Address width is exact. All 2^AW addresses are valid, with no wrap or aliasing logic.

## Timing
- Request sampled at edge E0 (IDLE). `ack` is high in the cycle following edge E(WAIT+1).
  - Request-to-`ack` latency is therefore WAIT+2 edges; with WAIT=0, `ack` appears 2 cycles after sampling.
- Write data is visible to a subsequent read once `ack` has fallen.
- Minimum spacing between two serviced requests is WAIT+4 cycles (ACK, RELEASE, IDLE sample).
- A read of an address written by the immediately preceding transaction returns the new value.

## Configuration
- Macro: `NOC_RESP_PARITY_EN`.
- **Defined:**
  - adds input `wpar` (1) and outputs `rpar` (1) and `par_err` (1);
  - the array stores DW+1 bits (data plus parity);
  - on write, if `wpar` differs from `^wdata`, the write still completes and `par_err` is set sticky until reset;
  - on read, `rpar` is the stored parity bit, valid with `ack`.
- **Undefined:** these ports, the parity storage and the error logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `noc_pkg` holds:
  - the FSM state enum (IDLE, ACCESS, ACK, RELEASE);
  - the op encoding (`OP_WR`, `OP_RD`);
  - default `DW`/`AW`, shared with the arbiter.
- One sub-module, `noc_resp_regfile`: 2^AW × DW(+1) array with synchronous write, registered read, and async clear.
- FSM and wait counter live in the top level.

## Test plan
- Reset, WAIT=0, write 0xA5 to addr 3 -> `ack` 2 cycles after sampling, `busy` high 3 cycles. Read addr 3 -> `rdata`=0xA5 in `ack` cycle.
- WAIT=3, read of unwritten addr 0xF -> `ack` at 5 cycles, `rdata`=0x00.
- `req_write` and `req_read` both high, addr 7, wdata 0x3C -> write serviced, single `ack`. After release, read addr 7 -> 0x3C.
- Request held high 10 cycles after `ack` -> exactly one `ack`; FSM stays in RELEASE until the request drops.
- `wrstn` pulsed low during ACCESS of a write to addr 2 with 0x55 -> no `ack`, outputs zero. A subsequent read of addr 2 -> 0x00.
- With `NOC_RESP_PARITY_EN`, write 0x01 with `wpar`=0 -> `par_err`=1 and stays set. Read back -> `rdata`=0x01, `rpar`=0.
